// File: rtl/bp_pkg.sv
// Branch-predictor shared constants and the global-history shift rule.
// The shift helper is width-generic so predictor index logic can reuse it.
package bp_pkg;

    localparam int BP_HIST_LEN   = 8;
    localparam int BP_CKPT_DEPTH = 4;
    localparam int BP_MAX_HIST   = 64;

    // New outcome enters at bit len-1 (the MSB of a len-bit history), LSB drops out.
    // Caller passes the history zero-extended to BP_MAX_HIST bits.
    function automatic logic [BP_MAX_HIST-1:0] bhr_shift(
        input logic [BP_MAX_HIST-1:0] hist,
        input logic                   new_bit,
        input int unsigned            len
    );
        logic [BP_MAX_HIST-1:0] ins;
        ins          = '0;
        ins[len-1]   = new_bit;
        return (hist >> 1) | ins;
    endfunction

endpackage

// File: rtl/branch_history_register_if.sv
// Front-end/resolve bundle for the speculative branch-history register.
// master = predictor/execute side, slave = the history register.
interface branch_history_register_if #(
    parameter int HIST_LEN   = 8,
    parameter int CKPT_DEPTH = 4
);
    localparam int CNT_W = $clog2(CKPT_DEPTH + 1);

    logic                predValid;
    logic                predTaken;
    logic                predReady;
    logic                resolveValid;
    logic                resolveMispredict;
    logic                resolveTaken;
    logic [HIST_LEN-1:0] history;
    logic [CNT_W-1:0]    ckptCount;
    logic [HIST_LEN-1:0] committedHistory;

    modport master (
        output predValid, predTaken, resolveValid, resolveMispredict, resolveTaken,
        input  predReady, history, ckptCount, committedHistory
    );

    modport slave (
        input  predValid, predTaken, resolveValid, resolveMispredict, resolveTaken,
        output predReady, history, ckptCount, committedHistory
    );

endinterface

// File: rtl/checkpoint_fifo.sv
// Circular in-order FIFO with push/pop/flush; head entry readable combinationally.
// Latency: push visible at head/count the cycle after the edge; flush is single-cycle.
// Backpressure: push ignored when full, pop ignored when empty; flush beats both.
module checkpoint_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push  = push && (count_q != CNT_W'(DEPTH));
    assign do_pop   = pop  && (count_q != '0);
    assign head_dat = mem_q[head_q];
    assign count    = count_q;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // Entries are left stale on flush; only the pointers collapse.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = push_dat;
                tail_d        = wrap_inc(tail_q);
            end
            if (do_pop) begin
                head_d = wrap_inc(head_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/branch_history_register.sv
// Speculative global branch history with per-branch checkpoints; BHR_COMMITTED_HISTORY_EN adds committedHistory.
// Latency: all outputs registered (1 cycle) except predReady, which is combinational from ckptCount.
// Backpressure: predReady low when CKPT_DEPTH branches are unresolved; predicts then are dropped.
module branch_history_register
    import bp_pkg::*;
#(
    parameter int HIST_LEN   = BP_HIST_LEN,
    parameter int CKPT_DEPTH = BP_CKPT_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    branch_history_register_if.slave    bus
);

    localparam int CNT_W = $clog2(CKPT_DEPTH + 1);

    logic [HIST_LEN-1:0] history_q, history_d;
    logic [HIST_LEN-1:0] head_dat;
    logic [CNT_W-1:0]    count;
    logic                res_fire;
    logic                mis_fire;
    logic                ok_pop;
    logic                push;

    function automatic logic [HIST_LEN-1:0] shift_h(
        input logic [HIST_LEN-1:0] h,
        input logic                b
    );
        return HIST_LEN'(bhr_shift(BP_MAX_HIST'(h), b, HIST_LEN));
    endfunction

    // Ready must not look at same-cycle resolve, so it is a pure count compare.
    assign bus.predReady = (count < CNT_W'(CKPT_DEPTH));

    assign res_fire = bus.resolveValid && (count != '0);
    assign mis_fire = res_fire && bus.resolveMispredict;
    assign ok_pop   = res_fire && !bus.resolveMispredict;
    // A predict alongside a mispredict is younger than the resolving branch and is squashed.
    assign push     = bus.predValid && bus.predReady && !mis_fire;

    checkpoint_fifo #(
        .WIDTH (HIST_LEN),
        .DEPTH (CKPT_DEPTH)
    ) u_ckpt (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_dat (history_q),
        .pop      (ok_pop),
        .flush    (mis_fire),
        .head_dat (head_dat),
        .count    (count)
    );

    always_comb begin
        history_d = history_q;
        if (mis_fire) begin
            history_d = shift_h(head_dat, bus.resolveTaken);
        end else if (push) begin
            history_d = shift_h(history_q, bus.predTaken);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history_q <= '0;
        end else begin
            history_q <= history_d;
        end
    end

    assign bus.history   = history_q;
    assign bus.ckptCount = count;

`ifdef BHR_COMMITTED_HISTORY_EN
    logic [HIST_LEN-1:0] committed_q, committed_d;

    always_comb begin
        committed_d = committed_q;
        if (res_fire) begin
            committed_d = shift_h(committed_q, bus.resolveTaken);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            committed_q <= '0;
        end else begin
            committed_q <= committed_d;
        end
    end

    assign bus.committedHistory = committed_q;
`else
    assign bus.committedHistory = '0;
`endif

endmodule

// File: tb/tb_branch_history_register.sv
// Scoreboard bench: stimulus pushes model-predicted outputs, a monitor pops and compares each cycle.
module tb_branch_history_register;

    localparam int HL    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [HL-1:0] hist;
        int            cnt;
        logic          rdy;
        logic [HL-1:0] comm;
    } exp_t;

    logic clk;
    logic reset;

    branch_history_register_if #(.HIST_LEN(HL), .CKPT_DEPTH(DEPTH)) bus ();

    branch_history_register #(.HIST_LEN(HL), .CKPT_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model: checkpoints as a plain queue of histories.
    logic [HL-1:0] m_hist;
    logic [HL-1:0] m_comm;
    logic [HL-1:0] m_ck[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [HL-1:0] sh(input logic [HL-1:0] h, input logic b);
        return {b, h[HL-1:1]};
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.hist = m_hist;
        e.cnt  = m_ck.size();
        e.rdy  = (m_ck.size() < DEPTH);
`ifdef BHR_COMMITTED_HISTORY_EN
        e.comm = m_comm;
`else
        e.comm = '0;
`endif
        return e;
    endfunction

    task automatic model_reset();
        m_hist = '0;
        m_comm = '0;
        m_ck.delete();
    endtask

    task automatic step(input logic pv, input logic pt, input logic rv, input logic rm, input logic rt);
        logic          acc;
        logic [HL-1:0] head;
        @(negedge clk);
        bus.predValid         = pv;
        bus.predTaken         = pt;
        bus.resolveValid      = rv;
        bus.resolveMispredict = rm;
        bus.resolveTaken      = rt;
        acc = pv && (m_ck.size() < DEPTH);
        if (rv && m_ck.size() > 0) begin
            head   = m_ck.pop_front();
            m_comm = sh(m_comm, rt);
            if (rm) begin
                m_hist = sh(head, rt);
                m_ck.delete();
            end else if (acc) begin
                m_ck.push_back(m_hist);
                m_hist = sh(m_hist, pt);
            end
        end else if (acc) begin
            m_ck.push_back(m_hist);
            m_hist = sh(m_hist, pt);
        end
        exp_q.push_back(snap());
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("history",   32'(bus.history),          32'(e.hist));
                chk("ckptCount", 32'(bus.ckptCount),        32'(e.cnt));
                chk("predReady", 32'(bus.predReady),        32'(e.rdy));
                chk("committed", 32'(bus.committedHistory), 32'(e.comm));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset                 = 1'b1;
        bus.predValid         = 1'b0;
        bus.predTaken         = 1'b0;
        bus.resolveValid      = 1'b0;
        bus.resolveMispredict = 1'b0;
        bus.resolveTaken      = 1'b0;
        model_reset();
        #1;
        chk("rst_hist",  32'(bus.history),          32'h0);
        chk("rst_cnt",   32'(bus.ckptCount),        32'h0);
        chk("rst_rdy",   32'(bus.predReady),        32'h1);
        chk("rst_comm",  32'(bus.committedHistory), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Predict T, N, T.
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        drain();
        chk("tp_hist_tnt", 32'(bus.history),   32'h0A0);
        chk("tp_cnt3",     32'(bus.ckptCount), 32'd3);

        // Correct resolve, then mispredict with actual taken.
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 1);
        drain();
        chk("tp_mis_hist", 32'(bus.history),   32'h0C0);
        chk("tp_mis_cnt",  32'(bus.ckptCount), 32'd0);

        // Fill to full, then an ignored predict.
        repeat (4) step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        drain();
        chk("tp_full_rdy", 32'(bus.predReady), 32'd0);
        chk("tp_full_cnt", 32'(bus.ckptCount), 32'd4);

        // Down to 2, then predict+correct resolve, then predict+mispredict.
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 1);
        drain();
        chk("tp_empty_cnt", 32'(bus.ckptCount), 32'd0);

        // Asynchronous reset between edges with three branches outstanding.
        repeat (3) step(1, 0, 0, 0, 0);
        drain();
        reset = 1'b1;
        #1;
        chk("async_hist", 32'(bus.history),   32'h0);
        chk("async_cnt",  32'(bus.ckptCount), 32'h0);
        chk("async_rdy",  32'(bus.predReady), 32'h1);
        model_reset();
        @(negedge clk);
        bus.predValid    = 1'b0;
        bus.resolveValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Committed history: resolve T, N, T from reset.
        repeat (3) step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 0);
        repeat (1) step(1, 1, 0, 0, 0);
        step(0, 0, 1, 0, 1);
        drain();
`ifdef BHR_COMMITTED_HISTORY_EN
        chk("tp_comm_tnt", 32'(bus.committedHistory), 32'h0A0);
`else
        chk("tp_comm_off", 32'(bus.committedHistory), 32'h0);
`endif

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 20),
                 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        bus.predValid    = 1'b0;
        bus.resolveValid = 1'b0;

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
